game_flow: RTL

Parametrised game-flow controller that replaces the single start latch at the top level of the dinosaur game. It debounces the jump button and sequences IDLE/RUN/OVER states. It generates the game-step tick with a speed ramp tied to score, and keeps a BCD score plus a high score. The tick drives player, enemy and score logic. The BCD outputs feed the seven-segment/dot-matrix score display.

---
 rtl/game_flow.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/game_flow.sv
// rtl/game_flow.sv - dinosaur game flow: button debounce, IDLE/RUN/OVER FSM, speed-ramped tick, BCD score/hiscore
module game_flow #(
    parameter int DIGITS    = 2,
    parameter int DEBOUNCE  = 4,
    parameter int TICK_INIT = 16,
    parameter int TICK_MIN  = 4,
    parameter int TICK_STEP = 2,
    parameter int LEVEL_PTS = 10
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                jump,
    input  logic                collide,
    output logic                tick,
    output logic                jump_pulse,
    output logic [1:0]          state,
    output logic                running,
    output logic [4*DIGITS-1:0] score,
    output logic [4*DIGITS-1:0] hiscore,
    output logic [3:0]          speed_level
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(TICK_INIT + 1);
    localparam int LW = $clog2(LEVEL_PTS + 1);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;

    logic                jump_meta;
    logic                sync;
    logic                deb;
    logic                press;
    logic [DW-1:0]       deb_cnt;
    logic [1:0]          state_next;
    logic [PW-1:0]       period;
    logic [PW-1:0]       period_dec;
    logic [PW-1:0]       tick_cnt;
    logic [LW-1:0]       level_cnt;
    logic                tick_due;
    logic                start_run;
    logic [4*DIGITS-1:0] score_inc;
    logic                carry;

    // Button is active-low; only the debounced falling edge counts as a press.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            jump_meta <= 1'b1;
            sync      <= 1'b1;
            deb       <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            jump_meta <= jump;
            sync      <= jump_meta;
            press     <= 1'b0;
            if (sync == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE - 1)) begin
                deb     <= sync;
                deb_cnt <= '0;
                press   <= ~sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (press)   state_next = S_RUN;
            S_RUN:   if (collide) state_next = S_OVER;
            S_OVER:  if (press)   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        running    = (state == S_RUN);
        jump_pulse = press & running;
        tick       = running & tick_due & ~collide;
    end

    assign tick_due   = (tick_cnt == '0);
    assign start_run  = (state == S_IDLE) & press;
    assign period_dec = (int'(period) >= TICK_MIN + TICK_STEP) ? period - PW'(TICK_STEP)
                                                               : PW'(TICK_MIN);

    // BCD increment with ripple carry; a carry out of the top digit means all nines, so hold.
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        if (carry) score_inc = score;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            score       <= '0;
            hiscore     <= '0;
            speed_level <= '0;
            period      <= PW'(TICK_INIT);
            tick_cnt    <= '0;
            level_cnt   <= '0;
        end else if (start_run) begin
            score       <= '0;
            speed_level <= '0;
            period      <= PW'(TICK_INIT);
            tick_cnt    <= PW'(TICK_INIT - 1);
            level_cnt   <= '0;
        end else if (running) begin
            tick_cnt <= tick_due ? period - 1'b1 : tick_cnt - 1'b1;
            if (collide) begin
                if (score > hiscore) hiscore <= score;
            end else if (tick_due) begin
                score <= score_inc;
                if (level_cnt == LW'(LEVEL_PTS - 1)) begin
                    level_cnt <= '0;
                    period    <= period_dec;
                    if (speed_level != 4'hF) speed_level <= speed_level + 4'd1;
                end else begin
                    level_cnt <= level_cnt + 1'b1;
                end
            end
        end
    end
endmodule
